// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time programmable clock divider with burst, stop and drain.
// Define CLK_DIV_CTRL_CNT_EN to expose the completed-period counter as period_cnt.
module clk_div_ctrl #(
    parameter int unsigned DW          = 16,
    parameter int unsigned PW          = 16,
    parameter int unsigned DEFAULT_DIV = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [DW-1:0] cfg_div,
    input  logic [PW-1:0] cfg_pulses,
    input  logic          start,
    input  logic          stop,
    output logic          busy,
    output logic          div_out,
    output logic          edge_stb,
    output logic          done
`ifdef CLK_DIV_CTRL_CNT_EN
    ,
    output logic [PW-1:0] period_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [PW-1:0] pulses_q, pulses_d;
    logic [DW-1:0] count_q, count_d;
    logic [PW-1:0] per_q, per_d;
    logic          out_q, out_d;
    logic          stb_q, stb_d;
    logic          done_q, done_d;

    logic          tick;
    logic          fall;
    logic [PW-1:0] per_inc;
    logic          burst_end;
    logic          stop_low;

    assign tick      = (count_q == div_q - DW'(1));
    assign fall      = tick && out_q;
    assign per_inc   = per_q + PW'(1);
    assign burst_end = fall && (pulses_q != '0) && (per_inc == pulses_q);
    // A stop seen while low ends at once; the low phase is already complete.
    assign stop_low  = stop && !out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            div_q    <= DW'(DEFAULT_DIV);
            pulses_q <= '0;
            count_q  <= '0;
            per_q    <= '0;
            out_q    <= 1'b0;
            stb_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            pulses_q <= pulses_d;
            count_q  <= count_d;
            per_q    <= per_d;
            out_q    <= out_d;
            stb_q    <= stb_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (burst_end || (stop && (!out_q || fall)))
                    state_d = IDLE;
                else if (stop)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (fall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        div_d    = div_q;
        pulses_d = pulses_q;
        count_d  = count_q;
        per_d    = per_q;
        out_d    = out_q;
        stb_d    = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    div_d    = (cfg_div == '0) ? DW'(1) : cfg_div;
                    pulses_d = cfg_pulses;
                end
                if (start) begin
                    count_d = '0;
                    per_d   = '0;
                    out_d   = 1'b0;
                end
            end
            RUN, DRAIN: begin
                done_d = (state_d == IDLE);
                if (!(state_q == RUN && stop_low)) begin
                    count_d = tick ? '0 : count_q + DW'(1);
                    if (tick) begin
                        out_d = !out_q;
                        stb_d = 1'b1;
                    end
                    if (fall) per_d = per_inc;
                end
            end
            default: ;
        endcase
    end

    assign cfg_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign div_out   = out_q;
    assign edge_stb  = stb_q;
    assign done      = done_q;
`ifdef CLK_DIV_CTRL_CNT_EN
    assign period_cnt = per_q;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed and randomized bench for clk_div_ctrl.
// Outputs are predicted from elapsed-cycle arithmetic since the last start.
module tb_clk_div_ctrl;

    localparam int DW  = 16;
    localparam int PW  = 16;
    localparam int DEF = 10;

    logic          clk;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [DW-1:0] cfg_div;
    logic [PW-1:0] cfg_pulses;
    logic          start;
    logic          stop;
    logic          busy;
    logic          div_out;
    logic          edge_stb;
    logic          done;
`ifdef CLK_DIV_CTRL_CNT_EN
    logic [PW-1:0] period_cnt;
`endif

    clk_div_ctrl #(
        .DW(DW),
        .PW(PW),
        .DEFAULT_DIV(DEF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_div(cfg_div),
        .cfg_pulses(cfg_pulses),
        .start(start),
        .stop(stop),
        .busy(busy),
        .div_out(div_out),
        .edge_stb(edge_stb),
        .done(done)
`ifdef CLK_DIV_CTRL_CNT_EN
        ,
        .period_cnt(period_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    bit cmp_en = 0;

    // Reference model: n = edges since start; level = (n/d)%2.
    bit            m_busy;
    bit            m_drain;
    longint        m_n;
    longint        m_end;
    longint        m_d;
    longint        m_p;
    bit            m_do;
    bit            m_es;
    bit            m_dn;
    logic [PW-1:0] m_per;

    always @(posedge clk) begin
        bit     imm;
        longint e;
        if (rst) begin
            m_busy = 0; m_drain = 0; m_d = DEF; m_p = 0;
            m_do = 0; m_es = 0; m_dn = 0; m_per = '0;
        end else if (!m_busy) begin
            m_es = 0;
            m_dn = 0;
            if (cfg_valid) begin
                m_d = (cfg_div == 0) ? 1 : longint'(cfg_div);
                m_p = longint'(cfg_pulses);
            end
            if (start) begin
                m_busy = 1; m_drain = 0; m_n = 0;
                m_end = m_p * 2 * m_d;
                m_do = 0; m_per = '0;
            end
        end else begin
            m_n++;
            imm = 0;
            if (!m_drain && stop) begin
                if (((m_n - 1) / m_d) % 2 == 0) begin
                    imm = 1;
                end else begin
                    e = ((m_n + 2 * m_d - 1) / (2 * m_d)) * 2 * m_d;
                    if (m_end == 0 || e < m_end) m_end = e;
                    m_drain = 1;
                end
            end
            if (imm) begin
                m_busy = 0; m_es = 0; m_dn = 1;
            end else begin
                m_do  = ((m_n / m_d) % 2) == 1;
                m_es  = (m_n % m_d) == 0;
                m_per = PW'(m_n / (2 * m_d));
                m_dn  = (m_n == m_end);
                if (m_dn) m_busy = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [4:0] act;
        logic [4:0] exp;
        if (cmp_en) begin
            act = {busy, cfg_ready, div_out, edge_stb, done};
            exp = {m_busy, !m_busy, m_do, m_es, m_dn};
            checks++;
            if (act !== exp) begin
                fails++;
                $display("FAIL model_cmp t=%0t {busy,ready,div,stb,done} got %b expected %b",
                         $time, act, exp);
            end
`ifdef CLK_DIV_CTRL_CNT_EN
            checks++;
            if (period_cnt !== m_per) begin
                fails++;
                $display("FAIL period_cnt t=%0t got %0d expected %0d", $time, period_cnt, m_per);
            end
`endif
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_count(input int nc, output int hi, output int es,
                             output int dn, output int bz);
        hi = 0; es = 0; dn = 0; bz = 0;
        repeat (nc) begin
            @(negedge clk);
            hi += int'(div_out);
            es += int'(edge_stb);
            dn += int'(done);
            bz += int'(busy);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic stop_pulse();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle();
    endtask

    task automatic go(input bit cfg, input int d, input int p);
        cfg_valid  = cfg;
        cfg_div    = DW'(d);
        cfg_pulses = PW'(p);
        start      = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        start     = 1'b0;
    endtask

    initial begin
        int hi, es, dn, bz;
        rst = 1'b1; cfg_valid = 1'b0; cfg_div = '0; cfg_pulses = '0;
        start = 1'b0; stop = 1'b0;
        @(negedge clk);
        cmp_en = 1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(cfg_ready), 64'd1);
        chk("rst_div", 64'(div_out), 64'd0);
        chk("rst_done", 64'(done), 64'd0);

        // Default divide: 10 high of 25, strobes at 10 and 20
        go(0, 0, 0);
        run_count(25, hi, es, dn, bz);
        chk("def_high", 64'(hi), 64'd10);
        chk("def_stb", 64'(es), 64'd2);
        chk("def_done", 64'(dn), 64'd0);
        // stop in low phase ends on the next edge
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("lowstop_busy", 64'(busy), 64'd0);
        chk("lowstop_done", 64'(done), 64'd1);
        chk("lowstop_stb", 64'(edge_stb), 64'd0);
        chk("lowstop_div", 64'(div_out), 64'd0);

        // Burst of 2 periods at div 3
        go(1, 3, 2);
        run_count(14, hi, es, dn, bz);
        chk("burst_busy", 64'(bz), 64'd11);
        chk("burst_high", 64'(hi), 64'd6);
        chk("burst_stb", 64'(es), 64'd4);
        chk("burst_done", 64'(dn), 64'd1);
        chk("burst_ready", 64'(cfg_ready), 64'd1);

        // Stop mid-high drains to the falling edge
        go(1, 4, 0);
        run_count(6, hi, es, dn, bz);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("drain_div", 64'(div_out), 64'd1);
        chk("drain_busy", 64'(busy), 64'd1);
        run_count(5, hi, es, dn, bz);
        chk("drain_done", 64'(dn), 64'd1);
        chk("drain_stb", 64'(es), 64'd1);
        chk("drain_high", 64'(hi), 64'd0);
        chk("drain_bz", 64'(bz), 64'd0);

        // div 0 acts as 1; config while busy is refused
        go(1, 0, 0);
        run_count(8, hi, es, dn, bz);
        chk("div0_stb", 64'(es), 64'd8);
        chk("div0_high", 64'(hi), 64'd4);
        cfg_valid = 1'b1; cfg_div = 16'd7; cfg_pulses = 16'd1;
        chk("busy_ready", 64'(cfg_ready), 64'd0);
        @(negedge clk);
        cfg_valid = 1'b0;
        stop_pulse();
        go(0, 0, 0);
        run_count(4, hi, es, dn, bz);
        chk("keep_div_stb", 64'(es), 64'd4);
        stop_pulse();

        // Reset mid-high phase reverts to default divide
        go(1, 5, 0);
        run_count(6, hi, es, dn, bz);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_div", 64'(div_out), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
`ifdef CLK_DIV_CTRL_CNT_EN
        chk("midrst_cnt", 64'(period_cnt), 64'd0);
`endif
        go(0, 0, 0);
        run_count(12, hi, es, dn, bz);
        chk("post_rst_high", 64'(hi), 64'd3);
        chk("post_rst_stb", 64'(es), 64'd1);
        stop_pulse();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            cfg_valid  = ($urandom_range(0, 4) == 0);
            cfg_div    = DW'($urandom_range(0, 5));
            cfg_pulses = PW'($urandom_range(0, 3));
            start      = ($urandom_range(0, 6) == 0);
            stop       = ($urandom_range(0, 19) == 0);
            @(negedge clk);
        end
        rst = 1'b0; cfg_valid = 1'b0; start = 1'b0;
        stop_pulse();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
